// File: rtl/regfile_mp.sv
// Multi-ported integer register file with a busy-bit scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [1:0]        we_i,
  input  logic [2*AW-1:0]   waddr_i,
  input  logic [2*XLEN-1:0] wdata_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]    rrdy_o,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_rd_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   busy_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW-1:0]   wa [2];
  logic [XLEN-1:0] wd [2];
  logic [1:0]      wv;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wa[k] = waddr_i[k*AW +: AW];
      wd[k] = wdata_i[k*XLEN +: XLEN];
      wv[k] = we_i[k] && (wa[k] != '0);
    end
  end

  // Port 1 is applied last so it wins a same-register collision
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (wv[k]) regs[wa[k]] <= wd[k];
    end
  end

  // Priority: flush > alloc > write-clear
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++)
      if (wv[k]) busy_d[wa[k]] = 1'b0;
    if (alloc_i && (alloc_rd_i != '0)) busy_d[alloc_rd_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) busy_q <= '0;
    else           busy_q <= busy_d;
  end

  assign busy_o = busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            rdy;

    assign ra = raddr_i[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic al;
    assign al = alloc_i && (alloc_rd_i == ra);
`endif

    always_comb begin
      data = regs[ra];
      rdy  = ~busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wv[0] && (wa[0] == ra)) begin
        data = wd[0];
        rdy  = ~al;
      end
      if (wv[1] && (wa[1] == ra)) begin
        data = wd[1];
        rdy  = ~al;
      end
`endif
      if (!reset_ni || (ra == '0)) begin
        data = '0;
        rdy  = 1'b1;
      end
    end

    assign rdata_o[p*XLEN +: XLEN] = data;
    assign rrdy_o[p] = rdy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, scoreboard queue,
// and hand sequences for forwarding and asynchronous reset.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata;
  logic [1:0]  rrdy;
  logic        alloc = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  regfile_mp dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .raddr_i    (raddr),
    .rdata_o    (rdata),
    .rrdy_o     (rrdy),
    .alloc_i    (alloc),
    .alloc_rd_i (alloc_rd),
    .flush_i    (flush),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        al;
    logic [4:0]  ard;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic [31:0] ebusy;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    we = '0;
    alloc = 1'b0;
    alloc_rd = '0;
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s[%0d] rdata0", tag, e.idx), rdata[31:0], e.e0);
      chk($sformatf("%s[%0d] rdata1", tag, e.idx), rdata[63:32], e.e1);
      chk($sformatf("%s[%0d] rrdy", tag, e.idx), {30'd0, rrdy},
          {30'd0, e.erdy});
      chk($sformatf("%s[%0d] busy", tag, e.idx), busy, e.ebusy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    //          we    wa0  wd0           wa1  wd1    al  ard  fl ra0 ra1 e0            e1           rdy    busy
    vecs[0]  = '{2'b01, 0, 32'hDEADBEEF, 0, 32'h0,   0, 0,  0, 0,  1,  32'h0,        32'h0,        2'b11, 32'h0};
    vecs[1]  = '{2'b11, 5, 32'h11,       5, 32'h22,  0, 0,  0, 5,  5,  32'h22,       32'h22,       2'b11, 32'h0};
    vecs[2]  = '{2'b11, 3, 32'h333,      4, 32'h444, 0, 0,  0, 3,  4,  32'h333,      32'h444,      2'b11, 32'h0};
    vecs[3]  = '{2'b00, 0, 32'h0,        0, 32'h0,   1, 7,  0, 7,  0,  32'h0,        32'h0,        2'b10, 32'h80};
    vecs[4]  = '{2'b01, 7, 32'hA5,       0, 32'h0,   0, 0,  0, 7,  5,  32'hA5,       32'h22,       2'b11, 32'h0};
    vecs[5]  = '{2'b10, 0, 32'h0,        7, 32'h5A,  1, 7,  0, 7,  7,  32'h5A,       32'h5A,       2'b00, 32'h80};
    vecs[6]  = '{2'b00, 0, 32'h0,        0, 32'h0,   1, 3,  0, 3,  7,  32'h333,      32'h5A,       2'b00, 32'h88};
    vecs[7]  = '{2'b00, 0, 32'h0,        0, 32'h0,   1, 4,  0, 4,  3,  32'h444,      32'h333,      2'b00, 32'h98};
    vecs[8]  = '{2'b00, 0, 32'h0,        0, 32'h0,   1, 9,  0, 9,  0,  32'h0,        32'h0,        2'b10, 32'h298};
    vecs[9]  = '{2'b01, 9, 32'h99,       0, 32'h0,   1, 10, 1, 9,  10, 32'h99,       32'h0,        2'b11, 32'h0};
    vecs[10] = '{2'b00, 0, 32'h0,        0, 32'h0,   1, 0,  0, 0,  0,  32'h0,        32'h0,        2'b11, 32'h0};
    vecs[11] = '{2'b11, 31, 32'hFFFFFFFF, 1, 32'h1,  0, 0,  0, 31, 1,  32'hFFFFFFFF, 32'h1,        2'b11, 32'h0};
    vecs[12] = '{2'b01, 31, 32'h31,      0, 32'h0,   1, 31, 0, 31, 31, 32'h31,       32'h31,       2'b00, 32'h80000000};

    quiet();
    #12;
    chk("reset rdata", rdata[31:0] | rdata[63:32], 32'h0);
    chk("reset busy", busy, 32'h0);
    chk("reset rrdy", {30'd0, rrdy}, 32'h3);
    next_cycle();
    reset_ni = 1'b1;

    foreach (vecs[i]) begin
      next_cycle();
      we = vecs[i].we;
      waddr = {vecs[i].wa1, vecs[i].wa0};
      wdata = {vecs[i].wd1, vecs[i].wd0};
      alloc = vecs[i].al;
      alloc_rd = vecs[i].ard;
      flush = vecs[i].fl;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      e = '{i, vecs[i].e0, vecs[i].e1, vecs[i].erdy, vecs[i].ebusy};
      sb.push_back(e);
      next_cycle();
      quiet();
      #2;
      check_pop("vec");
    end

    // Write 0x1234 to x2 while reading x2
    next_cycle();
    we = 2'b01;
    waddr = {5'd0, 5'd2};
    wdata = {32'h0, 32'h1234};
    raddr = {5'd2, 5'd2};
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same cycle", rdata[31:0], 32'h1234);
`else
    chk("bypass same cycle", rdata[31:0], 32'h0);
`endif
    chk("bypass rrdy", {31'd0, rrdy[0]}, 32'h1);
    e = '{100, 32'h1234, 32'h1234, 2'b11, 32'h80000000};
    sb.push_back(e);
    next_cycle();
    quiet();
    #2;
    check_pop("bypass next");

    // Asynchronous reset asserted mid-cycle with live traffic
    next_cycle();
    we = 2'b11;
    waddr = {5'd1, 5'd31};
    wdata = {32'h77, 32'h66};
    alloc = 1'b1;
    alloc_rd = 5'd5;
    raddr = {5'd1, 5'd31};
    #1;
    reset_ni = 1'b0;
    #1;
    chk("async rst rdata0", rdata[31:0], 32'h0);
    chk("async rst rdata1", rdata[63:32], 32'h0);
    chk("async rst busy", busy, 32'h0);
    chk("async rst rrdy", {30'd0, rrdy}, 32'h3);
    next_cycle();
    chk("rst held rdata0", rdata[31:0], 32'h0);
    chk("rst held busy", busy, 32'h0);
    quiet();
    reset_ni = 1'b1;
    raddr = {5'd5, 5'd5};
    #2;
    chk("post rst rdata5", rdata[31:0], 32'h0);
    next_cycle();
    raddr = {5'd1, 5'd31};
    #2;
    chk("post rst rdata31", rdata[31:0], 32'h0);
    chk("post rst rdata1", rdata[63:32], 32'h0);
    chk("post rst rrdy", {30'd0, rrdy}, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of two, at least 2); AW = log2(NREG) is derived.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1 to 4).
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port we_i, input, 2 bits: write enables; bit k belongs to write port k.
REQ-007 SHALL have port waddr_i, input, 2*AW bits: write addresses; port k occupies slice [k*AW +: AW].
REQ-008 SHALL have port wdata_i, input, 2*XLEN bits: write data, packed the same way.
REQ-009 SHALL have port raddr_i, input, NRD*AW bits: read addresses, packed per port.
REQ-010 SHALL have port rdata_o, output, NRD*XLEN bits: read data, packed per port.
REQ-011 SHALL have port rrdy_o, output, NRD bits: the addressed register holds no pending write.
REQ-012 SHALL have port alloc_i, input, 1 bit: mark register alloc_rd_i busy.
REQ-013 SHALL have port alloc_rd_i, input, AW bits: destination register to allocate.
REQ-014 SHALL have port flush_i, input, 1 bit: clear all busy bits.
REQ-015 SHALL have port busy_o, output, NREG bits: per-register scoreboard.

Function
REQ-016 Register 0 SHALL read as 0 at all times; writes and allocs to it are ignored; busy_o[0] is always 0, and rrdy_o is always 1 for address 0.
REQ-017 On a rising edge, when we_i[k] is 1 and waddr k is not 0, the addressed register SHALL take wdata k.
REQ-018 When both write ports target the same register, port 1 SHALL win.
REQ-019 Read ports SHALL be combinational and independent of one another; any number of ports may address the same register.
REQ-020 A write on port k SHALL clear busy for waddr k at the same edge.
REQ-021 alloc_i SHALL set busy for alloc_rd_i at the edge.
REQ-022 When alloc and a write target the same register in one cycle, the alloc SHALL win: busy ends at 1 and the data is still written.
REQ-023 flush_i SHALL clear all busy bits at the edge and SHALL override any alloc in the same cycle; writes still complete.
REQ-024 rrdy_o[p] SHALL equal the inverse of busy for raddr p, subject to REQ-016 and REQ-030.
REQ-025 Out-of-range addresses SHALL NOT occur: NREG is a power of two, so every AW-bit address is valid.

Reset
REQ-026 Assertion of reset_ni SHALL immediately, without waiting for a clock edge, set all registers to 0 and all busy bits to 0.
REQ-027 While reset is asserted, rdata_o SHALL be all 0 and rrdy_o all 1; writes and allocs are ignored.
REQ-028 Reset deassertion SHALL be synchronised externally; the first active edge follows deassertion.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined:
- a read whose address matches an enabled write port this cycle (address not 0) SHALL return that port's wdata, port 1 taking priority;
- rrdy_o for that port SHALL be 1 unless the same register is also being allocated this cycle.
REQ-031 With REGFILE_BYPASS_EN undefined, reads SHALL return stored contents only; new data becomes visible the cycle after the write edge, and rrdy_o follows the registered busy bits.

Verification
REQ-032 Reset scenario: reset_ni low mid-run, with no clock edge -> all rdata_o 0, busy_o 0, rrdy_o all 1.
REQ-033 Register 0 scenario: we_i=01, waddr0=0, wdata0=0xDEADBEEF, then read address 0 -> 0x00000000, rrdy_o 1.
REQ-034 Dual-write collision: both ports write register 5, with 0x11 on port 0 and 0x22 on port 1 -> next cycle, register 5 reads 0x22.
REQ-035 Scoreboard: alloc register 7 -> busy_o[7]=1 and rrdy_o=0 for reads of 7; write 0xA5 to 7 -> busy_o[7]=0, reads 0xA5; alloc and write 7 in the same cycle -> busy_o[7]=1.
REQ-036 Flush: alloc registers 3, 4 and 9 over three cycles, then flush_i together with an alloc of 10 -> busy_o all 0.
REQ-037 Bypass: write 0x1234 to register 2 while reading 2 -> with the macro, same cycle returns 0x1234; without it, the old value, then 0x1234 on the next cycle.
